sm_cfg_loader: RTL and testbench

SM_CFG_LOADER -- requirements
Module: sm_cfg_loader

---
 rtl/sm_cfg_pkg.sv | 29 ++
 rtl/sm_cfg_check.sv | 72 +++++++
 rtl/sm_cfg_loader.sv | 147 ++++++++++++++
 tb/tb_sm_cfg_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_cfg_pkg.sv
// Shared constants, state enum and sizing helper for the
// switch-matrix configuration loader.
package sm_cfg_pkg;

  localparam logic [2:0] SIDE_HIZ = 3'd0;
  localparam logic [2:0] SIDE_TOP = 3'd1;
  localparam logic [2:0] SIDE_RGT = 3'd2;
  localparam logic [2:0] SIDE_BOT = 3'd3;
  localparam logic [2:0] SIDE_LFT = 3'd4;

  localparam int SIDE_LSB = 0;
  localparam int SIDE_W   = 3;
  localparam int IDX_LSB  = 3;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int sm_ne(
    input int n_tb,
    input int n_lr
  );
    return 2 * n_tb + 2 * n_lr;
  endfunction

endpackage

// File: rtl/sm_cfg_check.sv
// Combinational legality check of one config entry against its
// target pin. Ports: i_entry, i_pin in; o_legal, o_entry out.
module sm_cfg_check
  import sm_cfg_pkg::*;
#(
  parameter int N_TB = 5,
  parameter int N_LR = 4,
  parameter int CW   = 6
) (
  input  logic [CW-1:0] i_entry,
  input  logic [$clog2(sm_ne(N_TB, N_LR))-1:0] i_pin,
  output logic          o_legal,
  output logic [CW-1:0] o_entry
);

  logic [SIDE_W-1:0] w_side;
  logic [IDX_W-1:0]  w_idx;
  logic [2:0]        w_tside;
  int                w_p;
  int                w_i;
  int                w_tidx;

  assign w_side = i_entry[SIDE_LSB +: SIDE_W];
  assign w_idx  = i_entry[IDX_LSB +: IDX_W];

  // Target pin side/index from the clockwise entry number.
  always_comb begin
    w_p     = int'(i_pin);
    w_tside = SIDE_TOP;
    w_tidx  = 0;
    unique case (1'b1)
      (w_p < N_TB): begin
        w_tside = SIDE_TOP;
        w_tidx  = w_p;
      end
      (w_p >= N_TB && w_p < N_TB + N_LR): begin
        w_tside = SIDE_RGT;
        w_tidx  = w_p - N_TB;
      end
      (w_p >= N_TB + N_LR &&
       w_p < 2 * N_TB + N_LR): begin
        w_tside = SIDE_BOT;
        w_tidx  = w_p - N_TB - N_LR;
      end
      default: begin
        w_tside = SIDE_LFT;
        w_tidx  = w_p - 2 * N_TB - N_LR;
      end
    endcase
  end

  always_comb begin
    w_i     = int'(w_idx);
    o_legal = 1'b1;
    unique case (w_side)
      SIDE_HIZ: o_legal = 1'b1;
      SIDE_TOP,
      SIDE_BOT: o_legal = (w_i < N_TB);
      SIDE_RGT,
      SIDE_LFT: o_legal = (w_i < N_LR);
      default:  o_legal = 1'b0;
    endcase
    if (w_side == w_tside && w_i == w_tidx)
      o_legal = 1'b0;
    // hi-Z entries keep no index; rejects become hi-Z
    if (!o_legal || w_side == SIDE_HIZ)
      o_entry = '0;
    else
      o_entry = i_entry;
  end

endmodule

// File: rtl/sm_cfg_loader.sv
// Loads NE checked entries into a shadow array and commits them
// atomically to cfg_bus; cfg_clear zeroes, errors are counted.
module sm_cfg_loader
  import sm_cfg_pkg::*;
#(
  parameter int N_TB = 5,
  parameter int N_LR = 4,
  parameter int CW   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_start,
  input  logic cfg_clear,
  input  logic cfg_valid,
  input  logic [CW-1:0] cfg_data,
  output logic cfg_ready,
  output logic [sm_ne(N_TB, N_LR)*CW-1:0] cfg_bus,
  output logic busy,
  output logic cfg_done,
  output logic cfg_err,
  output logic [4:0] err_cnt
);

  localparam int NE = sm_ne(N_TB, N_LR);
  localparam int PW = $clog2(NE);

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_cnt;
  logic [CW-1:0]   r_shadow [NE];
  logic [NE*CW-1:0] r_bus;
  logic [NE*CW-1:0] w_pack;
  logic            r_done;
  logic            r_err;
  logic [4:0]      r_err_cnt;

  logic            w_hs;
  logic            w_last;
  logic            w_restart;
  logic            w_write;
  logic            w_commit;
  logic            w_zero;
  logic            w_legal;
  logic [CW-1:0]   w_san;

  sm_cfg_check #(
    .N_TB(N_TB),
    .N_LR(N_LR),
    .CW  (CW)
  ) u_check (
    .i_entry(cfg_data),
    .i_pin  (r_cnt),
    .o_legal(w_legal),
    .o_entry(w_san)
  );

  assign w_hs   = cfg_valid && (r_state == ST_LOAD);
  assign w_last = (r_cnt == PW'(NE - 1));

  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_write   = 1'b0;
    w_commit  = 1'b0;
    w_zero    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (cfg_clear) begin
          w_zero = 1'b1;
        end else if (cfg_start) begin
          w_restart = 1'b1;
          w_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cfg_clear) begin
          w_zero = 1'b1;
          w_next = ST_IDLE;
        end else if (cfg_start) begin
          w_restart = 1'b1;
        end else if (w_hs) begin
          w_write = 1'b1;
          if (w_last)
            w_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_next = ST_IDLE;
        if (cfg_clear)
          w_zero = 1'b1;
        else
          w_commit = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pack = '0;
    for (int e = 0; e < NE; e++)
      w_pack[e*CW +: CW] = r_shadow[e];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bus     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      for (int e = 0; e < NE; e++)
        r_shadow[e] <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_commit;
      if (w_restart) begin
        r_cnt     <= '0;
        r_err     <= 1'b0;
        r_err_cnt <= '0;
        for (int e = 0; e < NE; e++)
          r_shadow[e] <= '0;
      end else if (w_write) begin
        r_shadow[r_cnt] <= w_san;
        r_cnt           <= r_cnt + PW'(1);
        if (!w_legal) begin
          r_err <= 1'b1;
          if (r_err_cnt != 5'd31)
            r_err_cnt <= r_err_cnt + 5'd1;
        end
      end
      if (w_zero)
        r_bus <= '0;
      else if (w_commit)
        r_bus <= w_pack;
    end
  end

  assign cfg_ready = (r_state == ST_LOAD);
  assign busy      = (r_state == ST_LOAD) ||
                     (r_state == ST_COMMIT);
  assign cfg_bus   = r_bus;
  assign cfg_done  = r_done;
  assign cfg_err   = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_sm_cfg_loader.sv
// Directed self-checking bench for sm_cfg_loader: table of
// load scenarios plus hand sequences for restart/clear/reset.
module tb_sm_cfg_loader;

  localparam int NE = 18;
  localparam int CW = 6;
  localparam int BW = NE * CW;

  logic clk;
  logic rst_n;
  logic cfg_start;
  logic cfg_clear;
  logic cfg_valid;
  logic [CW-1:0] cfg_data;
  logic cfg_ready;
  logic [BW-1:0] cfg_bus;
  logic busy;
  logic cfg_done;
  logic cfg_err;
  logic [4:0] err_cnt;

  int n_chk;
  int n_err;

  sm_cfg_loader #(
    .N_TB(5),
    .N_LR(4),
    .CW  (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_clear(cfg_clear),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_bus  (cfg_bus),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .err_cnt  (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef logic [CW-1:0] word_t;
  typedef word_t words_t [NE];

  typedef struct {
    int    pa;
    word_t wa;
    word_t xa;
    int    pb;
    word_t wb;
    word_t xb;
    int    nerr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(
    input string name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t base(input int e);
    return (e == 1) ? 6'b000_001 : 6'b001_001;
  endfunction

  function automatic logic [BW-1:0] pack(
    input words_t w
  );
    logic [BW-1:0] b;
    b = '0;
    for (int e = 0; e < NE; e++)
      b[e*CW +: CW] = w[e];
    return b;
  endfunction

  task automatic send(
    input words_t w,
    input int n,
    input bit rnd,
    input bit do_start
  );
    if (do_start) begin
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        while ($urandom_range(1, 0) == 0) begin
          cfg_valid = 1'b0;
          cfg_data  = word_t'($urandom);
          tick();
        end
      end
      cfg_valid = 1'b1;
      cfg_data  = w[i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  // Called #1 after the final handshake edge.
  task automatic commit_chk(
    input logic [BW-1:0] xbus,
    input logic xerr,
    input logic [4:0] xcnt,
    input logic [BW-1:0] oldbus
  );
    chk("done_pre", 128'(cfg_done), 128'(0));
    chk("bus_hold", 128'(cfg_bus), 128'(oldbus));
    chk("busy_cm", 128'(busy), 128'(1));
    tick();
    chk("done", 128'(cfg_done), 128'(1));
    chk("bus", 128'(cfg_bus), 128'(xbus));
    chk("err", 128'(cfg_err), 128'(xerr));
    chk("err_cnt", 128'(err_cnt), 128'(xcnt));
    chk("busy_end", 128'(busy), 128'(0));
    tick();
    chk("done_1cyc", 128'(cfg_done), 128'(0));
  endtask

  initial begin
    words_t w;
    words_t x;
    words_t bw;
    logic [BW-1:0] last_bus;

    n_chk = 0;
    n_err = 0;

    tbl[0] = '{-1, 6'b0, 6'b0, -1, 6'b0, 6'b0, 0};
    tbl[1] = '{3, 6'b000_101, 6'b0,
               6, 6'b100_010, 6'b0, 2};
    tbl[2] = '{0, 6'b000_001, 6'b0,
               -1, 6'b0, 6'b0, 1};
    tbl[3] = '{2, 6'b100_011, 6'b100_011,
               9, 6'b101_011, 6'b0, 1};
    tbl[4] = '{14, 6'b011_100, 6'b011_100,
               17, 6'b011_100, 6'b0, 1};
    tbl[5] = '{5, 6'b111_000, 6'b0,
               10, 6'b000_111, 6'b0, 1};
    tbl[6] = '{8, 6'b011_010, 6'b0,
               13, 6'b100_001, 6'b100_001, 1};
    tbl[7] = '{16, 6'b100_100, 6'b0,
               12, 6'b011_011, 6'b0, 2};
    tbl[8] = '{7, 6'b100_011, 6'b100_011,
               15, 6'b100_001, 6'b100_001, 0};

    for (int e = 0; e < NE; e++)
      bw[e] = base(e);

    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;

    #3;
    chk("rst_bus", 128'(cfg_bus), 128'(0));
    chk("rst_ready", 128'(cfg_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(cfg_done), 128'(0));
    chk("rst_err", 128'(cfg_err), 128'(0));
    chk("rst_cnt", 128'(err_cnt), 128'(0));
    #9;
    rst_n = 1'b1;
    tick();

    // valid in IDLE is ignored
    cfg_valid = 1'b1;
    cfg_data  = 6'b001_001;
    tick();
    chk("idle_ready", 128'(cfg_ready), 128'(0));
    cfg_valid = 1'b0;

    last_bus = '0;
    for (int t = 0; t < 9; t++) begin
      for (int e = 0; e < NE; e++) begin
        w[e] = base(e);
        x[e] = base(e);
      end
      if (tbl[t].pa >= 0) begin
        w[tbl[t].pa] = tbl[t].wa;
        x[tbl[t].pa] = tbl[t].xa;
      end
      if (tbl[t].pb >= 0) begin
        w[tbl[t].pb] = tbl[t].wb;
        x[tbl[t].pb] = tbl[t].xb;
      end
      send(w, NE, (t % 2) == 1, 1'b1);
      commit_chk(pack(x), tbl[t].nerr != 0,
                 5'(tbl[t].nerr), last_bus);
      last_bus = pack(x);
    end

    // restart mid-load: shadow and errors discarded
    w = bw;
    w[3] = 6'b000_101;
    send(w, 10, 1'b1, 1'b1);
    chk("part_err", 128'(cfg_err), 128'(1));
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("rs_err", 128'(cfg_err), 128'(0));
    chk("rs_cnt", 128'(err_cnt), 128'(0));
    chk("rs_ready", 128'(cfg_ready), 128'(1));
    chk("rs_bus", 128'(cfg_bus), 128'(last_bus));
    send(bw, NE, 1'b1, 1'b0);
    commit_chk(pack(bw), 1'b0, 5'd0, last_bus);

    // clear on the final handshake aborts
    send(bw, NE - 1, 1'b0, 1'b1);
    cfg_valid = 1'b1;
    cfg_data  = bw[NE-1];
    cfg_clear = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    chk("ab_busy", 128'(busy), 128'(0));
    chk("ab_ready", 128'(cfg_ready), 128'(0));
    chk("ab_bus", 128'(cfg_bus), 128'(0));
    chk("ab_done", 128'(cfg_done), 128'(0));
    tick();
    chk("ab_done2", 128'(cfg_done), 128'(0));
    chk("ab_bus2", 128'(cfg_bus), 128'(0));

    // clear in IDLE
    send(bw, NE, 1'b0, 1'b1);
    commit_chk(pack(bw), 1'b0, 5'd0, '0);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    chk("clr_bus", 128'(cfg_bus), 128'(0));
    chk("clr_done", 128'(cfg_done), 128'(0));

    // async reset mid-load
    send(bw, NE, 1'b0, 1'b1);
    commit_chk(pack(bw), 1'b0, 5'd0, '0);
    w = bw;
    w[0] = 6'b000_001;
    send(w, 5, 1'b0, 1'b1);
    cfg_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_bus", 128'(cfg_bus), 128'(0));
    chk("ar_ready", 128'(cfg_ready), 128'(0));
    chk("ar_busy", 128'(busy), 128'(0));
    chk("ar_done", 128'(cfg_done), 128'(0));
    chk("ar_err", 128'(cfg_err), 128'(0));
    chk("ar_cnt", 128'(err_cnt), 128'(0));
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_idle", 128'(cfg_ready), 128'(0));
    end
    cfg_valid = 1'b0;

    // fresh load after reset; start in COMMIT ignored
    send(bw, NE, 1'b0, 1'b1);
    chk("cm_busy", 128'(busy), 128'(1));
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("cm_done", 128'(cfg_done), 128'(1));
    chk("cm_bus", 128'(cfg_bus), 128'(pack(bw)));
    chk("cm_idle", 128'(busy), 128'(0));
    tick();
    chk("cm_idle2", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
